switch_conditioner: RTL and testbench

//   Input-side conditioner that produces clean control for the LED up/down counter.

---
 rtl/switch_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_switch_conditioner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises and debounces raw board switches, emits
// stable levels with one-cycle rise/fall strobes, and a free-running
// count-enable tick from a prescaler.
// Optional build macro: SW_DEBOUNCE_BYPASS_EN removes the debounce FSMs and
// passes the synchronised level straight to sw_stable (fast simulation).
module switch_conditioner #(
  parameter int N_SW      = 3,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16,
  parameter int TICK_DIV  = 25000000,
  parameter int TICK_W    = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            tick
);

  // Elaboration-time sanity checks on the parameter set.
  if (N_SW < 1) begin : g_bad_nsw
    $error("switch_conditioner: N_SW must be >= 1");
  end
  if (DB_CYCLES < 1 || (DB_CYCLES - 1) >= (2 ** DB_W)) begin : g_bad_db
    $error("switch_conditioner: DB_W cannot hold DB_CYCLES-1");
  end
  if (TICK_DIV < 2 || (TICK_DIV - 1) >= (2 ** TICK_W)) begin : g_bad_tick
    $error("switch_conditioner: TICK_W cannot hold TICK_DIV-1");
  end

  // ---------------------------------------------------------------------
  // Two-flop synchroniser; only s2 is used downstream.
  // ---------------------------------------------------------------------
  logic [N_SW-1:0] s1_q;
  logic [N_SW-1:0] s2_q;

  // Double-register the asynchronous switch levels into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs shared by both build variants.
  // ---------------------------------------------------------------------
  logic [N_SW-1:0] stable_q, stable_d;
  logic [N_SW-1:0] rise_q,   rise_d;
  logic [N_SW-1:0] fall_q,   fall_d;

`ifdef SW_DEBOUNCE_BYPASS_EN

  // Bypass: stable follows s2 one cycle later; strobes mark the difference.
  always_comb begin
    stable_d = s2_q;
    rise_d   = s2_q & ~stable_q;
    fall_d   = ~s2_q & stable_q;
  end

`else

  // ---------------------------------------------------------------------
  // Per-bit debounce FSM with a saturating-by-construction counter.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } db_state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  db_state_t       state_q [N_SW];
  db_state_t       state_d [N_SW];
  logic [DB_W-1:0] cnt_q   [N_SW];
  logic [DB_W-1:0] cnt_d   [N_SW];

  // Debounce state and counters for every switch bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state and output decode; the counter only advances while below
  // DB_LAST, and every state change reloads it to zero, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    for (int unsigned i = 0; i < N_SW; i++) begin
      case (state_q[i])
        S_LOW: begin
          if (s2_q[i]) begin
            state_d[i] = S_CHK_HI;
            cnt_d[i]   = '0;
          end
        end
        S_CHK_HI: begin
          if (!s2_q[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]  = S_HIGH;
            cnt_d[i]    = '0;
            stable_d[i] = 1'b1;
            rise_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_W'(1);
          end
        end
        S_HIGH: begin
          if (!s2_q[i]) begin
            state_d[i] = S_CHK_LO;
            cnt_d[i]   = '0;
          end
        end
        S_CHK_LO: begin
          if (s2_q[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]  = S_LOW;
            cnt_d[i]    = '0;
            stable_d[i] = 1'b0;
            fall_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_W'(1);
          end
        end
        default: begin
          state_d[i] = S_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`endif

  // Output registers; reset clears levels without producing a fall strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;

  // ---------------------------------------------------------------------
  // Prescaler: tick is high for one cycle after tcnt reaches TICK_DIV-1.
  // ---------------------------------------------------------------------
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tcnt_q, tcnt_d;
  logic              tick_q, tick_d;

  // Wrap the prescaler and raise the tick on the terminal count.
  always_comb begin
    tcnt_d = tcnt_q + TICK_W'(1);
    tick_d = 1'b0;
    if (tcnt_q == TICK_LAST) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed, table-driven bench for switch_conditioner with
// N_SW=3, DB_CYCLES=4, TICK_DIV=5.
module tb_switch_conditioner;

  localparam int N_SW      = 3;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 3;
  localparam int TICK_DIV  = 5;
  localparam int TICK_W    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_stable;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            tick;

  typedef struct {
    logic [N_SW-1:0] raw;
    logic [N_SW-1:0] st;
    logic [N_SW-1:0] ri;
    logic [N_SW-1:0] fa;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  always #5 clk = ~clk;

  switch_conditioner #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W),
    .TICK_DIV  (TICK_DIV),
    .TICK_W    (TICK_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .tick      (tick)
  );

  task automatic push(input int n, input logic [N_SW-1:0] raw,
                      input logic [N_SW-1:0] st, input logic [N_SW-1:0] ri,
                      input logic [N_SW-1:0] fa);
    vec_t v;
    v.raw = raw; v.st = st; v.ri = ri; v.fa = fa;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Tick model: high after every TICK_DIV-th edge since reset release.
  function automatic logic tick_exp(input int k);
    return (k > 0) && ((k % TICK_DIV) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check(input string nm, input logic [N_SW-1:0] st,
                       input logic [N_SW-1:0] ri, input logic [N_SW-1:0] fa,
                       input logic tk);
    checks++;
    if ({sw_stable, sw_rise, sw_fall, tick} !== {st, ri, fa, tk}) begin
      failures++;
      $display("FAIL %s: got stable=%b rise=%b fall=%b tick=%b, expected stable=%b rise=%b fall=%b tick=%b",
               nm, sw_stable, sw_rise, sw_fall, tick, st, ri, fa, tk);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      sw_raw = tbl[i].raw;
      step();
      check($sformatf("%s[%0d]", tag, i), tbl[i].st, tbl[i].ri, tbl[i].fa,
            tick_exp(edge_n));
    end
    tbl.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst    = 1'b1;
    sw_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 3'b000, 3'b000, 3'b000, 1'b0);
    rst    = 1'b0;
    edge_n = 0;

`ifdef SW_DEBOUNCE_BYPASS_EN
    // One-cycle raw pulse on bit 0: rise then fall on consecutive cycles.
    push(2, 3'b000, 3'b000, 3'b000, 3'b000);
    push(1, 3'b001, 3'b000, 3'b000, 3'b000);
    push(1, 3'b000, 3'b000, 3'b000, 3'b000);
    push(1, 3'b000, 3'b001, 3'b001, 3'b000);
    push(1, 3'b000, 3'b000, 3'b000, 3'b001);
    push(4, 3'b000, 3'b000, 3'b000, 3'b000);
    run_table("bypass");
`else
    // Idle 20 cycles: only ticks at 5, 10, 15, 20.
    push(20, 3'b000, 3'b000, 3'b000, 3'b000);
    // Bit 0 rises, committed 6 edges after the sampling edge.
    push(6,  3'b001, 3'b000, 3'b000, 3'b000);
    push(1,  3'b001, 3'b001, 3'b001, 3'b000);
    push(1,  3'b001, 3'b001, 3'b000, 3'b000);
    // Bit 1 bounces every 2 cycles, then holds high.
    push(2,  3'b011, 3'b001, 3'b000, 3'b000);
    push(2,  3'b001, 3'b001, 3'b000, 3'b000);
    push(2,  3'b011, 3'b001, 3'b000, 3'b000);
    push(2,  3'b001, 3'b001, 3'b000, 3'b000);
    push(6,  3'b011, 3'b001, 3'b000, 3'b000);
    push(1,  3'b011, 3'b011, 3'b010, 3'b000);
    push(1,  3'b011, 3'b011, 3'b000, 3'b000);
    // All high, then all low at once: simultaneous falls.
    push(6,  3'b111, 3'b011, 3'b000, 3'b000);
    push(1,  3'b111, 3'b111, 3'b100, 3'b000);
    push(1,  3'b111, 3'b111, 3'b000, 3'b000);
    push(6,  3'b000, 3'b111, 3'b000, 3'b000);
    push(1,  3'b000, 3'b000, 3'b000, 3'b111);
    push(1,  3'b000, 3'b000, 3'b000, 3'b000);
    // Bit 2 raised; after 5 more edges its FSM sits in S_CHK_HI with cnt=2.
    push(5,  3'b100, 3'b000, 3'b000, 3'b000);
    run_table("seq");

    // Asynchronous reset mid-debounce (tick is high at this point).
    rst = 1'b1;
    #1;
    check("rst_async_clear", 3'b000, 3'b000, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", 3'b000, 3'b000, 3'b000, 1'b0);
    release_reset();

    // Held input re-debounces from scratch.
    push(6, 3'b100, 3'b000, 3'b000, 3'b000);
    push(1, 3'b100, 3'b100, 3'b100, 3'b000);
    push(1, 3'b100, 3'b100, 3'b000, 3'b000);
    run_table("redebounce");

    // Reset while stable high: level clears, no fall strobe afterwards.
    rst = 1'b1;
    #1;
    check("rst_stable_clear", 3'b000, 3'b000, 3'b000, 1'b0);
    sw_raw = '0;
    release_reset();
    push(8, 3'b000, 3'b000, 3'b000, 3'b000);
    run_table("nofall");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
